// File: rtl/dh_modexp_scheduler.sv
// dh_modexp_scheduler: round-robin shared square-and-multiply modexp engine for two requesters
module dh_modexp_scheduler #(
  parameter int W  = 8,
  parameter int EW = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          req_a,
  input  logic [W-1:0]  base_a,
  input  logic [EW-1:0] exp_a,
  input  logic [W-1:0]  mod_a,
  input  logic          req_b,
  input  logic [W-1:0]  base_b,
  input  logic [EW-1:0] exp_b,
  input  logic [W-1:0]  mod_b,
  output logic          ack_a,
  output logic          ack_b,
  output logic [W-1:0]  result,
  output logic          result_valid,
  output logic          result_id,
  output logic          err,
  output logic          busy
);
  localparam int IW = EW > 1 ? $clog2(EW) : 1;
  localparam logic [IW-1:0] TOP = IW'(EW - 1);
  typedef enum logic [1:0] {IDLE, STEP_SQ, STEP_MUL, DONE} state_t;
  state_t state, nxt;
  logic last_grant, id, gnt, gnt_b, bit_set, last;
  logic [W-1:0] base_r, mod_r, acc, acc_nxt, m_in, one_m;
  logic [EW-1:0] exp_r;
  logic [IW-1:0] idx;
  logic [2*W-1:0] sq_m, mul_m;
  assign busy = state != IDLE;
  assign gnt = state == IDLE && (req_a || req_b);
  assign gnt_b = req_b && (!req_a || !last_grant);
  assign m_in = gnt_b ? mod_b : mod_a;
  assign one_m = {{(W-1){1'b0}}, |m_in[W-1:1]};
  assign bit_set = exp_r[idx];
  assign last = idx == '0;
  assign sq_m = ({{W{1'b0}}, acc} * {{W{1'b0}}, acc}) % {{W{1'b0}}, mod_r};
  assign mul_m = ({{W{1'b0}}, acc} * {{W{1'b0}}, base_r}) % {{W{1'b0}}, mod_r};
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    acc_nxt = acc;
    case (state)
      IDLE:     nxt = !gnt ? IDLE : m_in == '0 ? DONE : STEP_SQ;
      STEP_SQ: begin
        acc_nxt = sq_m[W-1:0];
        nxt = bit_set ? STEP_MUL : last ? DONE : STEP_SQ;
      end
      STEP_MUL: begin
        acc_nxt = mul_m[W-1:0];
        nxt = last ? DONE : STEP_SQ;
      end
      default:  nxt = IDLE;
    endcase
  end
  // outputs are registered on the edge entering DONE, so a zero modulus reports in the grant cycle
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      last_grant <= 1'b1;
      id <= 1'b0;
      base_r <= '0;
      mod_r <= '0;
      exp_r <= '0;
      acc <= '0;
      idx <= '0;
      ack_a <= 1'b0;
      ack_b <= 1'b0;
      result <= '0;
      result_valid <= 1'b0;
      result_id <= 1'b0;
      err <= 1'b0;
    end else begin
      ack_a <= gnt && !gnt_b;
      ack_b <= gnt && gnt_b;
      result_valid <= nxt == DONE;
      err <= gnt && nxt == DONE;
      if (nxt == DONE) begin
        result <= gnt ? '0 : acc_nxt;
        result_id <= gnt ? gnt_b : id;
      end
      if (gnt) begin
        base_r <= gnt_b ? base_b : base_a;
        exp_r <= gnt_b ? exp_b : exp_a;
        mod_r <= m_in;
        id <= gnt_b;
        acc <= one_m;
        idx <= TOP;
        if (req_a && req_b) last_grant <= gnt_b;
      end else if (state == STEP_SQ || state == STEP_MUL) begin
        acc <= acc_nxt;
        if ((state == STEP_MUL || !bit_set) && !last) idx <= idx - IW'(1);
      end
    end
endmodule

// File: tb/tb_dh_modexp_scheduler.sv
// tb_dh_modexp_scheduler: directed checks of arbitration, latency, results and reset abort
module tb_dh_modexp_scheduler;
  logic CLK = 0, RST = 1;
  logic req_a = 0, req_b = 0;
  logic [7:0] base_a = 0, mod_a = 0, base_b = 0, mod_b = 0;
  logic [3:0] exp_a = 0, exp_b = 0;
  logic ack_a, ack_b, result_valid, result_id, err, busy;
  logic [7:0] result;
  int errors = 0, checks = 0;

  dh_modexp_scheduler #(.W(8), .EW(4)) dut (
    .CLK(CLK), .RST(RST),
    .req_a(req_a), .base_a(base_a), .exp_a(exp_a), .mod_a(mod_a),
    .req_b(req_b), .base_b(base_b), .exp_b(exp_b), .mod_b(mod_b),
    .ack_a(ack_a), .ack_b(ack_b), .result(result), .result_valid(result_valid),
    .result_id(result_id), .err(err), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_a(input logic [7:0] b, input logic [3:0] e, input logic [7:0] m);
    base_a = b; exp_a = e; mod_a = m; req_a = 1;
  endtask

  task automatic set_b(input logic [7:0] b, input logic [3:0] e, input logic [7:0] m);
    base_b = b; exp_b = e; mod_b = m; req_b = 1;
  endtask

  // waits for the grant of side s; samples land 1 time unit after each edge
  task automatic wait_ack(input bit s, input int n, input bit drop);
    int k = 0;
    do begin
      @(posedge CLK); #1; k++;
    end while (!(s ? ack_b : ack_a) && k < 40);
    check("ack_lat", k, n);
    check("ack_other", s ? ack_a : ack_b, 0);
    check("busy", busy, 1);
    if (drop) begin
      if (s) req_b = 0;
      else req_a = 0;
    end
  endtask

  // k counts edges after the grant edge; acks while busy are counted as failures
  task automatic wait_res(input int lat, input logic [7:0] res, input bit id, input bit e);
    int k = 0, acks = 0;
    while (!result_valid && k < 40) begin
      @(posedge CLK); #1; k++;
      acks += int'(ack_a) + int'(ack_b);
    end
    check("res_lat", k, lat);
    check("result", result, res);
    check("result_id", result_id, id);
    check("err", err, e);
    check("busy_acks", acks, 0);
    @(posedge CLK); #1;
    check("valid_pulse", result_valid, 0);
    check("result_hold", result, res);
  endtask

  initial begin
    int pulses;
    #2;
    check("rst_ack_a", ack_a, 0);
    check("rst_ack_b", ack_b, 0);
    check("rst_result", result, 0);
    check("rst_valid", result_valid, 0);
    check("rst_id", result_id, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    #10 RST = 0;
    @(posedge CLK); #1;
    // 3^5 mod 7 = 5, latency 4+2
    set_a(3, 5, 7);
    wait_ack(0, 1, 1);
    wait_res(6, 5, 0, 0);
    // tie: A (2^9 mod 11 = 6) first, then B (5^3 mod 13 = 8, latency 4+2)
    set_a(2, 9, 11);
    set_b(5, 3, 13);
    wait_ack(0, 1, 1);
    wait_res(6, 6, 0, 0);
    wait_ack(1, 1, 1);
    wait_res(6, 8, 1, 0);
    // last tie went to A, so with both held the order is B, A, B, A
    set_a(3, 5, 7);
    set_b(5, 3, 13);
    for (int i = 0; i < 4; i++) begin
      wait_ack(i % 2 == 0, 1, 0);
      if (i == 3) begin req_a = 0; req_b = 0; end
      if (i % 2 == 0) wait_res(6, 8, 1, 0);
      else wait_res(6, 5, 0, 0);
    end
    set_a(2, 0, 7);
    wait_ack(0, 1, 1);
    wait_res(4, 1, 0, 0);
    set_b(9, 3, 1);
    wait_ack(1, 1, 1);
    wait_res(6, 0, 1, 0);
    set_a(4, 6, 0);
    wait_ack(0, 1, 1);
    wait_res(0, 0, 0, 1);
    // abort 3^15 mod 8 two cycles after grant
    set_a(3, 15, 8);
    wait_ack(0, 1, 1);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_valid", result_valid, 0);
    check("abort_ack", ack_a, 0);
    #2 RST = 0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge CLK); #1;
      pulses += int'(result_valid) + int'(ack_a) + int'(ack_b);
    end
    check("abort_quiet", pulses, 0);
    check("abort_busy_after", busy, 0);
    set_a(3, 15, 8);
    wait_ack(0, 1, 1);
    wait_res(8, 3, 0, 0);
    // reset restored last_grant to B, so a tie goes to A
    set_a(3, 5, 7);
    set_b(5, 3, 13);
    wait_ack(0, 1, 1);
    wait_res(6, 5, 0, 0);
    wait_ack(1, 1, 1);
    wait_res(6, 8, 1, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
